// File: rtl/branch_predict_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_resolve
//  Brief    : 2-bit BHT branch predictor with full-operand EX resolution,
//             mispredict redirect and saturating branch statistics.
//  Revision : 1.0  initial release
// ============================================================================
module branch_predict_resolve #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [XLEN-1:0]  if_pc_i,
    output logic             if_pred_taken_o,
    input  logic             ex_valid_i,
    input  logic             ex_stall_i,
    input  logic             ex_Branch_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic [XLEN-1:0]  ex_pc_i,
    input  logic [XLEN-1:0]  ex_rs1_i,
    input  logic [XLEN-1:0]  ex_rs2_i,
    input  logic             ex_pred_taken_i,
    output logic             branch_taken_o,
    output logic             mispredict_o,
    output logic [CNT_W-1:0] branch_count_o,
    output logic [CNT_W-1:0] mispredict_count_o
);
    localparam int               IDX       = $clog2(BHT_ENTRIES);
    localparam logic [1:0]       C_WEAK_NT = 2'b01;
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    logic [IDX-1:0]   w_if_idx, w_ex_idx;
    logic             w_active, w_valid_f3, w_outcome, w_update;
    logic [1:0]       w_ex_cnt, w_bht_d;
    logic             w_unused_pc_bits;

    assign w_if_idx = if_pc_i[IDX+1:2];
    assign w_ex_idx = ex_pc_i[IDX+1:2];
    assign w_unused_pc_bits = ^{if_pc_i[XLEN-1:IDX+2], if_pc_i[1:0],
                                ex_pc_i[XLEN-1:IDX+2], ex_pc_i[1:0]};

    // Lookup reads the array directly; a concurrent update is not bypassed.
    assign if_pred_taken_o = bht_q[w_if_idx][1];

    assign w_active   = ex_valid_i & ex_Branch_i & ~ex_stall_i;
    assign w_valid_f3 = (ex_funct3_i[2:1] != 2'b01);

    always_comb begin
        w_outcome = 1'b0;
        case (ex_funct3_i)
            3'b000:  w_outcome = (ex_rs1_i == ex_rs2_i);
            3'b001:  w_outcome = (ex_rs1_i != ex_rs2_i);
            3'b100:  w_outcome = ($signed(ex_rs1_i) <  $signed(ex_rs2_i));
            3'b101:  w_outcome = ($signed(ex_rs1_i) >= $signed(ex_rs2_i));
            3'b110:  w_outcome = (ex_rs1_i <  ex_rs2_i);
            3'b111:  w_outcome = (ex_rs1_i >= ex_rs2_i);
            default: w_outcome = 1'b0;
        endcase
    end

    assign branch_taken_o = w_active & w_outcome;
    assign mispredict_o   = w_active & (branch_taken_o != ex_pred_taken_i);
    assign w_update       = w_active & w_valid_f3;

    // Saturating 2-bit counter step, read-modify-write on the current entry.
    assign w_ex_cnt = bht_q[w_ex_idx];
    always_comb begin
        w_bht_d = w_ex_cnt;
        if (branch_taken_o) begin
            if (w_ex_cnt != 2'b11) w_bht_d = w_ex_cnt + 2'b01;
        end else begin
            if (w_ex_cnt != 2'b00) w_bht_d = w_ex_cnt - 2'b01;
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (w_update && !(&branch_count_q))
            branch_count_d = branch_count_q + C_CNT_ONE;
        if (mispredict_o && !(&mispredict_count_q))
            mispredict_count_d = mispredict_count_q + C_CNT_ONE;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= C_WEAK_NT;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            if (w_update) bht_q[w_ex_idx] <= w_bht_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count_o     = branch_count_q;
    assign mispredict_count_o = mispredict_count_q;
endmodule
`default_nettype wire

// File: tb/tb_branch_predict_resolve.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predict_resolve
//  Brief    : Directed self-checking bench for branch_predict_resolve.
//  Revision : 1.0  initial release
// ============================================================================
module tb_branch_predict_resolve;
    localparam int XLEN        = 32;
    localparam int BHT_ENTRIES = 64;
    localparam int CNT_W       = 4;

    logic             clock_i = 1'b0;
    logic             reset_i;
    logic [XLEN-1:0]  if_pc_i;
    logic             if_pred_taken_o;
    logic             ex_valid_i, ex_stall_i, ex_Branch_i, ex_pred_taken_i;
    logic [2:0]       ex_funct3_i;
    logic [XLEN-1:0]  ex_pc_i, ex_rs1_i, ex_rs2_i;
    logic             branch_taken_o, mispredict_o;
    logic [CNT_W-1:0] branch_count_o, mispredict_count_o;

    int n_tests = 0;
    int n_fail  = 0;

    branch_predict_resolve #(
        .XLEN        (XLEN),
        .BHT_ENTRIES (BHT_ENTRIES),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clock_i            (clock_i),
        .reset_i            (reset_i),
        .if_pc_i            (if_pc_i),
        .if_pred_taken_o    (if_pred_taken_o),
        .ex_valid_i         (ex_valid_i),
        .ex_stall_i         (ex_stall_i),
        .ex_Branch_i        (ex_Branch_i),
        .ex_funct3_i        (ex_funct3_i),
        .ex_pc_i            (ex_pc_i),
        .ex_rs1_i           (ex_rs1_i),
        .ex_rs2_i           (ex_rs2_i),
        .ex_pred_taken_i    (ex_pred_taken_i),
        .branch_taken_o     (branch_taken_o),
        .mispredict_o       (mispredict_o),
        .branch_count_o     (branch_count_o),
        .mispredict_count_o (mispredict_count_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic idle();
        ex_valid_i      = 1'b0;
        ex_Branch_i     = 1'b0;
        ex_stall_i      = 1'b0;
        ex_pred_taken_i = 1'b0;
        ex_funct3_i     = 3'b000;
        ex_pc_i         = '0;
        ex_rs1_i        = '0;
        ex_rs2_i        = '0;
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic pred, input logic stall);
        ex_valid_i      = 1'b1;
        ex_Branch_i     = 1'b1;
        ex_pc_i         = pc;
        ex_funct3_i     = f3;
        ex_rs1_i        = a;
        ex_rs2_i        = b;
        ex_pred_taken_i = pred;
        ex_stall_i      = stall;
        #1;
    endtask

    task automatic check_counts(input string tag, input int bc, input int mc);
        check({tag, "_bc"}, 32'(branch_count_o), bc);
        check({tag, "_mc"}, 32'(mispredict_count_o), mc);
    endtask

    task automatic check_pred(input string tag, input logic [31:0] pc, input logic exp);
        if_pc_i = pc;
        #1;
        check(tag, 32'(if_pred_taken_o), 32'(exp));
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < BHT_ENTRIES; i++)
            check_pred($sformatf("%s_idx%0d", tag, i), 32'(i) << 2, 1'b0);
    endtask

    initial begin
        logic       tr_pred [3];
        logic       tr_mis  [3];
        logic [2:0] sg_f3   [4];
        logic       sg_tk   [4];
        tr_pred = '{1'b0, 1'b1, 1'b1};
        tr_mis  = '{1'b1, 1'b0, 1'b0};
        sg_f3   = '{3'b100, 3'b110, 3'b101, 3'b111};
        sg_tk   = '{1'b1, 1'b0, 1'b0, 1'b1};

        reset_i = 1'b1;
        if_pc_i = '0;
        idle();
        step();
        step();
        reset_i = 1'b0;
        check_counts("reset", 0, 0);
        sweep("reset");

        // Train pc 0x40 with the prediction the pipeline would carry along.
        for (int k = 0; k < 3; k++) begin
            if_pc_i = 32'h40;
            drive(32'h40, 3'b000, 32'd5, 32'd5, tr_pred[k], 1'b0);
            check($sformatf("train%0d_pred", k), 32'(if_pred_taken_o), 32'(tr_pred[k]));
            check($sformatf("train%0d_taken", k), 32'(branch_taken_o), 32'd1);
            check($sformatf("train%0d_mis", k), 32'(mispredict_o), 32'(tr_mis[k]));
            step();
        end
        idle();
        check_counts("train", 3, 1);
        check_pred("train_final_pred", 32'h40, 1'b1);

        // Signed vs unsigned with rs1=-1, rs2=1 at pc 0x80 (counter 01->10->01->00->01).
        for (int k = 0; k < 4; k++) begin
            drive(32'h80, sg_f3[k], 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
            check($sformatf("sgn%0d_taken", k), 32'(branch_taken_o), 32'(sg_tk[k]));
            check($sformatf("sgn%0d_mis", k), 32'(mispredict_o), 32'(sg_tk[k]));
            step();
        end
        idle();
        check_counts("sgn", 7, 3);
        check_pred("sgn_pred80", 32'h80, 1'b0);

        drive(32'h80, 3'b001, 32'd1, 32'd2, 1'b0, 1'b1);
        check("stall_taken", 32'(branch_taken_o), 32'd0);
        check("stall_mis", 32'(mispredict_o), 32'd0);
        step();
        idle();
        check_counts("stall", 7, 3);
        check_pred("stall_pred80", 32'h80, 1'b0);

        drive(32'h80, 3'b000, 32'd9, 32'd9, 1'b0, 1'b0);
        check("beq80_mis", 32'(mispredict_o), 32'd1);
        step();
        idle();
        check_counts("beq80", 8, 4);
        check_pred("beq80_pred", 32'h80, 1'b1);

        drive(32'h80, 3'b010, 32'd3, 32'd3, 1'b1, 1'b0);
        check("inv_taken", 32'(branch_taken_o), 32'd0);
        check("inv_mis", 32'(mispredict_o), 32'd1);
        step();
        idle();
        check_counts("inv", 8, 5);
        check_pred("inv_pred80", 32'h80, 1'b1);

        // Ten invalid mispredicts fill the 4-bit counter, the eleventh must hold it.
        for (int k = 0; k < 11; k++) begin
            drive(32'h80, 3'b011, 32'd0, 32'd0, 1'b1, 1'b0);
            step();
        end
        idle();
        check_counts("missat", 8, 15);

        for (int k = 0; k < 9; k++) begin
            drive(32'hC0, 3'b000, 32'd7, 32'd7, 1'b1, 1'b0);
            step();
        end
        idle();
        check_counts("brsat", 15, 15);

        // 0x140 aliases 0x40 (entry at 11); fetch sees the pre-update value.
        if_pc_i = 32'h40;
        drive(32'h140, 3'b000, 32'd1, 32'd2, 1'b1, 1'b0);
        check("alias1_taken", 32'(branch_taken_o), 32'd0);
        check("alias1_fetch", 32'(if_pred_taken_o), 32'd1);
        step();
        idle();
        check_pred("alias1_pred40", 32'h40, 1'b1);
        if_pc_i = 32'h140;
        drive(32'h40, 3'b000, 32'd1, 32'd2, 1'b1, 1'b0);
        check("alias2_fetch", 32'(if_pred_taken_o), 32'd1);
        step();
        idle();
        check_pred("alias2_pred140", 32'h140, 1'b0);

        // Reset wins over a concurrent resolve; outputs still driven.
        reset_i = 1'b1;
        drive(32'h80, 3'b000, 32'd3, 32'd3, 1'b0, 1'b0);
        check("rstmid_taken", 32'(branch_taken_o), 32'd1);
        check("rstmid_mis", 32'(mispredict_o), 32'd1);
        step();
        reset_i = 1'b0;
        idle();
        check_counts("rstmid", 0, 0);
        sweep("rstmid");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
